dac_spi_driver: RTL
===================

Name: dac_spi_driver

Overview:
- Downstream consumer of the triangle and other waveform generators.
- Takes a 16-bit sample through a valid/ready handshake and saturates it to 12 bits.
- Serialises the result as a 16-bit SPI frame ({2'b00, PD=2'b00, code[11:0]}) to an external 12-bit DAC (DAC121S101-class: SYNC active-low, data sampled on SCLK falling edge).
- Gives the waveform path a physical analogue output.

Parameters:
- CLK_DIV, 2: clk cycles per SCLK half-period; legal range ≥1.
- FRAME_BITS, 16: bits per SPI frame; fixed by the DAC and not to be overridden.
- DATA_BITS, 12: DAC resolution; saturation limit is 2^DATA_BITS-1.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset; asynchronous, active-high.
- ena, input, 1: enables acceptance of new samples.
- sample, input, 16: unsigned sample from the waveform generator.
- sample_valid, input, 1: sample is presented this cycle.
- ready, output, 1: block can accept a sample; equals ena && state==IDLE (combinational).
- sync_n, output, 1: DAC frame select, active-low.
- sclk, output, 1: SPI clock; idle high.
- sdata, output, 1: SPI data, MSB first.
- busy, output, 1: high from acceptance until return to IDLE.
- frame_done, output, 1: one-cycle pulse in the cycle sync_n returns high.

Behaviour:
- Reset (async, immediate): sync_n=1, sclk=1, sdata=0, busy=0, frame_done=0, state=IDLE, divider and bit counter cleared.
- Reset mid-frame aborts the frame immediately; no partial-frame completion after rst deasserts.
- Acceptance: on a clk edge with sample_valid && ready, latch frame = {4'b0000, code}.
  - code = 12'hFFF if sample > 4095, else sample[11:0].
  - busy goes high on the same edge.
- sample_valid while not ready: ignored, not queued.
- Divider: a tick every CLK_DIV clk cycles while busy; all sclk/sync_n/sdata changes occur on ticks only. Divider restarts at acceptance.
- FSM IDLE: sync_n=1, sclk=1. Goes to SETUP on acceptance.
- FSM SETUP, 1 half-period:
  - sync_n=0, sclk=1, sdata=frame[15].
  - On tick, go to SHIFT_LO.
- FSM SHIFT_LO, 1 half-period per bit:
  - sclk=0; the falling edge entering this state is the DAC sample point.
  - On tick, go to SHIFT_HI.
- FSM SHIFT_HI, 1 half-period per bit:
  - sclk=1; sdata advances to the next bit when entering this state.
  - On tick, if bit counter < 15, increment and go to SHIFT_LO; else go to HOLD.
- FSM HOLD, 2 half-periods:
  - sync_n=1 on entry, with frame_done pulsed that cycle; sclk=1, sdata=0.
  - After 2 ticks, go to IDLE and drop busy.
- Edge count: exactly 16 sclk falling edges per frame while sync_n=0; sdata stable for ≥CLK_DIV cycles around each falling edge.
- Latency: acceptance edge to ready high again (ena held) = 35*CLK_DIV clk cycles; 70 at default. Back-to-back frames: next acceptance possible on that cycle.
- ena deasserted mid-frame: frame completes normally; ready stays 0 afterwards while ena=0.
- ena=0 in IDLE: outputs hold idle levels.
- sample changing after acceptance: no effect on the current frame.

Decomposition:
- Package dac_spi_pkg holds:
  - FSM state enum (IDLE, SETUP, SHIFT_LO, SHIFT_HI, HOLD);
  - FRAME_BITS=16, DATA_BITS=12, PD_NORMAL=2'b00, SAT_MAX=12'hFFF.
- One sub-module, sclk_tick_gen:
  - CLK_DIV-cycle counter with sync restart input and tick output;
  - async active-high rst; reused by later serial-output blocks.

Test Plan:
- Reset/idle: assert rst mid-sim with random inputs -> sync_n=1, sclk=1, sdata=0, busy=0, frame_done=0 without waiting for a clk edge.
- Single frame: ena=1, sample=16'h0ABC, valid 1 cycle, CLK_DIV=2 -> bits captured on sclk falls = 16'h0ABC, 16 falls, frame_done once, ready back after 70 cycles.
- Saturation: sample=16'h1234 -> frame 16'h0FFF; sample=16'h0FFF -> 16'h0FFF; sample=0 -> 16'h0000.
- Handshake: valid held high with changing samples 0x001, 0x002, ... -> each frame carries the value present at its acceptance edge; samples offered while busy are dropped; back-to-back frames 70 cycles apart.
- ena drop mid-frame (after bit 5) -> frame completes intact, then ready=0 and no new frame while valid=1.
- Reset mid-frame at bit 8, release, send 16'h0555 -> sync_n high immediately at rst; the following frame is exactly 16'h0555 with 16 falls; CLK_DIV=1 rerun gives latency 35.

Source files
------------

// File: rtl/dac_spi_driver_pkg.sv
// Shared types, constants and frame-building helpers for the DAC SPI driver.
package dac_spi_pkg;

  localparam int              FRAME_BITS = 16;
  localparam int              DATA_BITS  = 12;
  localparam logic [1:0]      PD_NORMAL  = 2'b00;
  localparam logic [11:0]     SAT_MAX    = 12'hFFF;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_LO,
    SHIFT_HI,
    HOLD
  } state_e;

  // Clamp an unsigned 16-bit sample to the DAC code range.
  function automatic logic [DATA_BITS-1:0] sat_code(input logic [15:0] s);
    if (s > {4'b0000, SAT_MAX}) begin
      return SAT_MAX;
    end
    return s[DATA_BITS-1:0];
  endfunction

  // Build the 16-bit DAC word: two don't-care zeros, power-down bits, code.
  function automatic logic [FRAME_BITS-1:0] make_frame(input logic [15:0] s);
    return {2'b00, PD_NORMAL, sat_code(s)};
  endfunction

endpackage

// File: rtl/dac_spi_driver_if.sv
// Sample handshake between a waveform generator (master) and the DAC driver (slave).
interface dac_spi_driver_if;

  logic        ena;
  logic [15:0] sample;
  logic        sample_valid;
  logic        ready;

  modport master (
    output ena,
    output sample,
    output sample_valid,
    input  ready
  );

  modport slave (
    input  ena,
    input  sample,
    input  sample_valid,
    output ready
  );

endinterface

// File: rtl/dac_spi_driver_sclk_tick_gen.sv
// Divider producing a one-cycle tick every CLK_DIV clocks while enabled.
// restart_i re-aligns the phase so the first tick lands CLK_DIV cycles later.
module sclk_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic restart_i,
  output logic tick_o
);

  localparam int                CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  // Next count: clear on restart, when idle, or on wrap; otherwise count up.
  always_comb begin
    cnt_d = cnt_q;
    if (restart_i || !en_i || tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Divider count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dac_spi_driver.sv
// Accepts 16-bit samples, saturates them to 12 bits and shifts them out as
// 16-bit SPI frames to a SYNC-framed DAC that samples on falling SCLK.
module dac_spi_driver
  import dac_spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  dac_spi_driver_if.slave  s_if,
  output logic             sync_n,
  output logic             sclk,
  output logic             sdata,
  output logic             busy,
  output logic             frame_done
);

  localparam int              CNT_W    = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

  state_e                  state_q;
  state_e                  state_d;
  logic [FRAME_BITS-1:0]   shreg_q;
  logic [FRAME_BITS-1:0]   shreg_d;
  logic [CNT_W-1:0]        bit_cnt_q;
  logic [CNT_W-1:0]        bit_cnt_d;
  logic                    frame_done_q;
  logic                    frame_done_d;
  logic                    tick;
  logic                    accept;
  logic                    active;

  assign active      = (state_q != IDLE);
  assign s_if.ready  = s_if.ena && (state_q == IDLE);
  assign accept      = s_if.sample_valid && s_if.ready;
  assign busy        = active;
  assign frame_done  = frame_done_q;

  sclk_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk       (clk),
    .rst       (rst),
    .en_i      (active),
    .restart_i (accept),
    .tick_o    (tick)
  );

  // FSM state register; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: every transition after acceptance waits for a divider tick.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (accept) state_d = SETUP;
      SETUP:    if (tick)   state_d = SHIFT_LO;
      SHIFT_LO: if (tick)   state_d = SHIFT_HI;
      SHIFT_HI: if (tick)   state_d = (bit_cnt_q == LAST_BIT) ? HOLD : SHIFT_LO;
      HOLD:     if (tick && (bit_cnt_q == CNT_W'(1))) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // FSM outputs: SPI pins decoded from state; sdata is the shifter MSB while framed.
  always_comb begin
    sync_n = 1'b1;
    sclk   = 1'b1;
    sdata  = 1'b0;
    case (state_q)
      SETUP: begin
        sync_n = 1'b0;
        sdata  = shreg_q[FRAME_BITS-1];
      end
      SHIFT_LO: begin
        sync_n = 1'b0;
        sclk   = 1'b0;
        sdata  = shreg_q[FRAME_BITS-1];
      end
      SHIFT_HI: begin
        sync_n = 1'b0;
        sdata  = shreg_q[FRAME_BITS-1];
      end
      default: ;
    endcase
  end

  // Shifter, bit/hold counter and frame_done next values.
  // The shifter advances on the rising SCLK edge so data is stable across each fall.
  // The bit counter is reused to count the two HOLD half-periods.
  always_comb begin
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d   = make_frame(s_if.sample);
          bit_cnt_d = '0;
        end
      end
      SHIFT_LO: begin
        if (tick) shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
      end
      SHIFT_HI: begin
        if (tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d    = '0;
            frame_done_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (tick) bit_cnt_d = bit_cnt_q + 1'b1;
      end
      default: ;
    endcase
  end

  // Control registers: bit counter and the frame_done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Frame shift register; only observed while SYNC is low, so it needs no reset.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

endmodule
